// File: rtl/multi_cycle_mips.sv
// multi_cycle_mips: multi-cycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB) with handshaked memories
module multi_cycle_mips #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          DMEM_AW     = 7,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        IR_addr,
    output logic               IR_req,
    input  logic [31:0]        IR,
    input  logic               IR_valid,
    output logic               CEN,
    output logic               WEN,
    output logic               OEN,
    output logic [DMEM_AW-1:0] A,
    output logic [31:0]        Data2Mem,
    input  logic [31:0]        ReadDataMem,
    input  logic               mem_ready,
    output logic               instr_done,
    output logic               illegal,
    output logic               bus_err
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    state_t state, nstate;
    logic [31:0] pc, ir, a_reg, b_reg, imm_ext, pc4, br_tgt, alu_out, mdr;
    logic [31:0] alu_res, alu_b, simm, j_tgt, wd, rs_val, rt_val;
    logic [31:0] rf [32];
    logic [7:0]  tcnt;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wa;
    logic is_r, r_alu, is_jr, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic legal, to_wb, is_mem, taken, mem_exit;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign is_r    = op == 6'h00;
    assign r_alu   = is_r && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 || funct == 6'h25 || funct == 6'h2A);
    assign is_jr   = is_r && funct == 6'h08;
    assign is_addi = op == 6'h08;
    assign is_lw   = op == 6'h23;
    assign is_sw   = op == 6'h2B;
    assign is_beq  = op == 6'h04;
    assign is_bne  = op == 6'h05;
    assign is_j    = op == 6'h02;
    assign is_jal  = op == 6'h03;
    assign legal   = r_alu || is_jr || is_addi || is_lw || is_sw || is_beq || is_bne || is_j || is_jal;
    assign to_wb   = r_alu || is_addi || is_jal;
    assign is_mem  = is_lw || is_sw;
    assign simm    = {{16{ir[15]}}, ir[15:0]};
    assign j_tgt   = {pc4[31:28], ir[25:0], 2'b00};
    assign taken   = is_beq ? (a_reg == b_reg) : (a_reg != b_reg);
    assign rs_val  = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rt_val  = (rt == 5'd0) ? 32'd0 : rf[rt];
    assign alu_b   = is_r ? b_reg : imm_ext;
    assign alu_res = !is_r           ? a_reg + alu_b :
                     funct == 6'h22  ? a_reg - alu_b :
                     funct == 6'h24  ? a_reg & alu_b :
                     funct == 6'h25  ? a_reg | alu_b :
                     funct == 6'h2A  ? {31'd0, $signed(a_reg) < $signed(alu_b)} :
                                       a_reg + alu_b;
    assign mem_exit = mem_ready || tcnt == 8'(MEM_TIMEOUT - 1);
    assign wa      = is_jal ? 5'd31 : is_r ? rd : rt;
    assign wd      = is_jal ? pc4 : is_lw ? mdr : alu_out;
    assign IR_addr = pc;
    assign IR_req  = state == FETCH && !rst_n;

    // State register
    always_ff @(posedge clk)
        state <= rst_n ? FETCH : nstate;

    // Next-state selection; a successful load continues to WB, everything else leaving MEM retires
    always_comb begin
        nstate = state;
        case (state)
            FETCH:   nstate = IR_valid ? DECODE : FETCH;
            DECODE:  nstate = EXEC;
            EXEC:    nstate = is_mem ? MEM : to_wb ? WB : FETCH;
            MEM:     nstate = !mem_exit ? MEM : (mem_ready && is_lw) ? WB : FETCH;
            WB:      nstate = FETCH;
            default: nstate = FETCH;
        endcase
    end

    // Register file write port; $0 is never written so it always reads back as zero
    always_ff @(posedge clk)
        if (!rst_n && state == WB && wa != 5'd0) rf[wa] <= wd;

    // Datapath, PC update, data-port strobes, timeout counter and sticky flags
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc         <= RESET_PC;
            CEN        <= 1'b1;
            WEN        <= 1'b1;
            OEN        <= 1'b1;
            A          <= '0;
            Data2Mem   <= '0;
            instr_done <= 1'b0;
            illegal    <= 1'b0;
            bus_err    <= 1'b0;
            tcnt       <= '0;
        end else begin
            instr_done <= state != FETCH && nstate == FETCH;
            if (state == FETCH && IR_valid) ir <= IR;
            if (state == DECODE) begin
                a_reg   <= rs_val;
                b_reg   <= rt_val;
                imm_ext <= simm;
                pc4     <= pc + 32'd4;
                br_tgt  <= pc + 32'd4 + {simm[29:0], 2'b00};
            end
            if (state == EXEC) begin
                alu_out <= alu_res;
                if (!legal) illegal <= 1'b1;
                if (!legal) pc <= pc4;
                if (is_beq || is_bne) pc <= taken ? br_tgt : pc4;
                if (is_j || is_jal) pc <= j_tgt;
                if (is_jr) pc <= a_reg;
                if (is_mem) begin
                    CEN <= 1'b0;
                    WEN <= !is_sw;
                    OEN <= is_sw;
                    A   <= alu_res[DMEM_AW-1:0];
                end
                if (is_sw) Data2Mem <= b_reg;
            end
            if (state == MEM) begin
                tcnt <= mem_exit ? 8'd0 : tcnt + 8'd1;
                if (mem_ready) mdr <= ReadDataMem;
                if (!mem_ready && mem_exit) bus_err <= 1'b1;
                if (mem_exit) begin
                    CEN <= 1'b1;
                    WEN <= 1'b1;
                    OEN <= 1'b1;
                end
                if (nstate == FETCH) pc <= pc4;
            end
            if (state == WB && !is_jal) pc <= pc4;
        end
    end
endmodule

// File: tb/tb_multi_cycle_mips.sv
// tb_multi_cycle_mips: directed instruction sequence with hand-computed register, PC and bus expectations
module tb_multi_cycle_mips;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] IR_addr, IR, Data2Mem, ReadDataMem, ir_word;
    logic        IR_req, IR_valid, CEN, WEN, OEN, mem_ready, instr_done, illegal, bus_err;
    logic [6:0]  A, a_seen;
    logic        mem_en;
    logic [7:0]  mwait, mcnt;
    logic [31:0] dmem [128];
    int          compared = 0, mismatched = 0, wen_cnt = 0, oen_cnt = 0;
    int          cyc, w0, o0;

    multi_cycle_mips dut (
        .clk(clk), .rst_n(rst_n), .IR_addr(IR_addr), .IR_req(IR_req), .IR(IR), .IR_valid(IR_valid),
        .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem),
        .mem_ready(mem_ready), .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign IR          = ir_word;
    assign ReadDataMem = dmem[A];
    assign mem_ready   = mem_en && !CEN && mcnt == mwait;

    // Data memory model: programmable wait states, word 8 preloaded during reset
    always @(posedge clk) begin
        mcnt <= CEN ? 8'd0 : mcnt + 8'd1;
        if (rst_n) dmem[8] <= 32'h7FFF_FFFF;
        else if (mem_ready && !WEN) dmem[A] <= Data2Mem;
        if (!WEN) wen_cnt <= wen_cnt + 1;
        if (!OEN) oen_cnt <= oen_cnt + 1;
        if (!CEN) a_seen <= A;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] ins, input logic [7:0] w, output int n);
        ir_word = ins;
        mwait = w;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_done && n < 64);
        chk("retire_seen", {31'd0, instr_done}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ir_word = 32'h0;
        IR_valid = 1'b1;
        mem_en = 1'b1;
        mwait = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_ir_req", {31'd0, IR_req}, 32'd0);
        chk("rst_strobes", {29'd0, CEN, WEN, OEN}, 32'h7);
        chk("rst_a_d2m", {25'd0, A} | Data2Mem, 32'd0);
        chk("rst_flags", {29'd0, instr_done, illegal, bus_err}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("fetch1_req", {31'd0, IR_req}, 32'd1);
        chk("fetch1_addr", IR_addr, 32'h0);
        run(32'h20010005, 8'd0, cyc);
        chk("addi_cycles", cyc, 4);
        chk("addi_r1", dut.rf[1], 32'd5);
        chk("addi_pc", IR_addr, 32'h04);
        run(32'h8C010008, 8'd0, cyc);
        chk("lw0_cycles", cyc, 5);
        chk("lw0_r1", dut.rf[1], 32'h7FFF_FFFF);
        run(32'h20020001, 8'd0, cyc);
        run(32'h00221820, 8'd0, cyc);
        chk("add_wrap_r3", dut.rf[3], 32'h8000_0000);
        run(32'h0061202A, 8'd0, cyc);
        chk("slt_signed_r4", dut.rf[4], 32'd1);
        chk("slt_pc", IR_addr, 32'h14);
        w0 = wen_cnt;
        o0 = oen_cnt;
        run(32'hAC010004, 8'd2, cyc);
        chk("sw_cycles", cyc, 6);
        chk("sw_addr", {25'd0, a_seen}, 32'd4);
        chk("sw_wen_cycles", wen_cnt - w0, 3);
        chk("sw_oen_cycles", oen_cnt - o0, 0);
        chk("sw_mem", dmem[4], 32'h7FFF_FFFF);
        chk("sw_strobes_off", {29'd0, CEN, WEN, OEN}, 32'h7);
        o0 = oen_cnt;
        run(32'h8C050004, 8'd2, cyc);
        chk("lw_cycles", cyc, 7);
        chk("lw_r5", dut.rf[5], 32'h7FFF_FFFF);
        chk("lw_oen_cycles", oen_cnt - o0, 3);
        chk("lw_pc", IR_addr, 32'h1C);
        run(32'h08000004, 8'd0, cyc);
        chk("j_cycles", cyc, 3);
        chk("j_pc", IR_addr, 32'h10);
        run(32'h1000FFFC, 8'd0, cyc);
        chk("beq_taken_pc", IR_addr, 32'h04);
        run(32'h08000004, 8'd0, cyc);
        run(32'h14250010, 8'd0, cyc);
        chk("bne_nt_cycles", cyc, 3);
        chk("bne_nt_pc", IR_addr, 32'h14);
        run(32'h14200002, 8'd0, cyc);
        chk("bne_taken_pc", IR_addr, 32'h20);
        run(32'h0C000100, 8'd0, cyc);
        chk("jal_cycles", cyc, 4);
        chk("jal_pc", IR_addr, 32'h400);
        chk("jal_r31", dut.rf[31], 32'h24);
        run(32'h03E00008, 8'd0, cyc);
        chk("jr_cycles", cyc, 3);
        chk("jr_pc", IR_addr, 32'h24);
        run(32'h00023022, 8'd0, cyc);
        chk("sub_r6", dut.rf[6], 32'hFFFF_FFFF);
        run(32'h00263824, 8'd0, cyc);
        chk("and_r7", dut.rf[7], 32'h7FFF_FFFF);
        run(32'h00434025, 8'd0, cyc);
        chk("or_r8", dut.rf[8], 32'h8000_0001);
        run(32'h0023482A, 8'd0, cyc);
        chk("slt_r9", dut.rf[9], 32'd0);
        chk("alu_pc", IR_addr, 32'h34);
        run(32'h8C0A0008, 8'd14, cyc);
        chk("lw_last_cycle_cycles", cyc, 19);
        chk("lw_last_cycle_r10", dut.rf[10], 32'h7FFF_FFFF);
        chk("lw_last_cycle_buserr", {31'd0, bus_err}, 32'd0);
        mem_en = 1'b0;
        run(32'h8C050000, 8'd0, cyc);
        mem_en = 1'b1;
        chk("timeout_cycles", cyc, 18);
        chk("timeout_buserr", {31'd0, bus_err}, 32'd1);
        chk("timeout_r5_kept", dut.rf[5], 32'h7FFF_FFFF);
        chk("timeout_pc", IR_addr, 32'h3C);
        run(32'hFC000000, 8'd0, cyc);
        chk("illegal_cycles", cyc, 3);
        chk("illegal_flag", {31'd0, illegal}, 32'd1);
        chk("illegal_pc", IR_addr, 32'h40);
        run(32'h20000007, 8'd0, cyc);
        run(32'h00005820, 8'd0, cyc);
        chk("r0_reads_zero", dut.rf[11], 32'd0);
        IR_valid = 1'b0;
        ir_word = 32'h200CFFFD;
        repeat (3) @(negedge clk);
        chk("fetch_wait_hold", {IR_req, IR_addr[30:0]}, {1'b1, 31'h48});
        IR_valid = 1'b1;
        run(32'h200CFFFD, 8'd0, cyc);
        chk("fetch_wait_cycles", cyc, 4);
        chk("fetch_wait_r12", dut.rf[12], 32'hFFFF_FFFD);
        mem_en = 1'b0;
        ir_word = 32'h8C050000;
        cyc = 0;
        while (CEN && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_mem_cen", {31'd0, CEN}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_mem_rst_cen", {31'd0, CEN}, 32'd1);
        chk("mid_mem_rst_pc", IR_addr, 32'h0);
        rst_n = 1'b0;
        mem_en = 1'b1;
        #1;
        chk("after_rst_req", {31'd0, IR_req}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
